palette_loader: RTL and testbench

- Sequences a user palette download into the 64-entry × 24-bit palette RAM of the video block, driving its `load_color`, `load_color_index` and `load_color_data` inputs.
- Assembles the incoming byte stream into RGB triplets.
- Holds each assembled entry until the video pipeline grants a write slot, so display lookups are never corrupted, and stalls the download source while an entry is pending.
- Sits between the file-download interface and the video block.

---
 rtl/palette_loader.sv | 139 +++++++++++++
 tb/tb_palette_loader.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/palette_loader.sv
// Palette download sequencer: packs the download byte stream into RGB entries and
// writes each one into the video palette RAM only when the video side grants a slot.
module palette_loader #(
  parameter int          ENTRIES   = 64,
  parameter logic [7:0]  PAL_INDEX = 8'd2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        dl_download,
  input  logic [7:0]  dl_index,
  input  logic        dl_wr,
  input  logic [7:0]  dl_data,
  output logic        dl_wait,
  input  logic        wr_slot,
  output logic        load_color,
  output logic [5:0]  load_color_index,
  output logic [23:0] load_color_data,
  output logic        pal_loaded,
  output logic        overrun
);

  localparam int CW = $clog2(ENTRIES + 1);

  typedef enum logic [2:0] {IDLE, COLLECT, PENDING, WRITE, DONE} state_e;

  state_e        state_q;
  logic          act_q;
  logic [1:0]    lane_q;
  logic [CW-1:0] count_q;
  logic          extra_q;
  logic [7:0]    red_q, green_q;
  logic          dl_wait_q, load_color_q, pal_loaded_q, overrun_q;
  logic [5:0]    index_q;
  logic [23:0]   data_q;

  logic act, act_rise, full;

  assign act  = dl_download && (dl_index == PAL_INDEX);
  // NOTE: the rising edge compares live act against last cycle's act, so a dl_wr
  // arriving together with the first active cycle is still captured as lane 0.
  assign act_rise = act && !act_q;
  assign full     = (count_q == CW'(ENTRIES));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      act_q        <= 1'b0;
      lane_q       <= 2'd0;
      count_q      <= '0;
      extra_q      <= 1'b0;
      red_q        <= 8'd0;
      green_q      <= 8'd0;
      dl_wait_q    <= 1'b0;
      load_color_q <= 1'b0;
      pal_loaded_q <= 1'b0;
      overrun_q    <= 1'b0;
      index_q      <= 6'd0;
      data_q       <= 24'd0;
    end else begin
      act_q <= act;
      if (act_rise) begin
        // A new download always restarts cleanly, even over a pending entry.
        state_q      <= COLLECT;
        lane_q       <= 2'd0;
        count_q      <= '0;
        extra_q      <= 1'b0;
        pal_loaded_q <= 1'b0;
        overrun_q    <= 1'b0;
        dl_wait_q    <= 1'b0;
        load_color_q <= 1'b0;
        if (dl_wr) begin
          red_q  <= dl_data;
          lane_q <= 2'd1;
        end
      end else begin
        if (act && dl_wr && dl_wait_q) overrun_q <= 1'b1;
        unique case (state_q)
          IDLE: begin
            state_q <= IDLE;
          end
          COLLECT: begin
            if (!act) begin
              state_q <= DONE;
            end else if (dl_wr) begin
              if (full) begin
                extra_q <= 1'b1;
              end else begin
                unique case (lane_q)
                  2'd0: begin
                    red_q  <= dl_data;
                    lane_q <= 2'd1;
                  end
                  2'd1: begin
                    green_q <= dl_data;
                    lane_q  <= 2'd2;
                  end
                  default: begin
                    data_q    <= {red_q, green_q, dl_data};
                    index_q   <= count_q[5:0];
                    lane_q    <= 2'd0;
                    dl_wait_q <= 1'b1;
                    state_q   <= PENDING;
                  end
                endcase
              end
            end
          end
          PENDING: begin
            if (wr_slot) begin
              load_color_q <= 1'b1;
              state_q      <= WRITE;
            end
          end
          WRITE: begin
            load_color_q <= 1'b0;
            dl_wait_q    <= 1'b0;
            count_q      <= count_q + CW'(1);
            state_q      <= act ? COLLECT : DONE;
          end
          DONE: begin
            pal_loaded_q <= full && (lane_q == 2'd0) && !extra_q;
            state_q      <= IDLE;
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign dl_wait          = dl_wait_q;
  assign load_color       = load_color_q;
  assign load_color_index = index_q;
  assign load_color_data  = data_q;
  assign pal_loaded       = pal_loaded_q;
  assign overrun          = overrun_q;

endmodule

// File: tb/tb_palette_loader.sv
// Self-checking bench for palette_loader: table-driven downloads, randomized
// downloads against a list-slicing reference model, and hand-written corner cases.
module tb_palette_loader;
  localparam int ENTRIES = 64;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        dl_download = 1'b0;
  logic [7:0]  dl_index = 8'd0;
  logic        dl_wr = 1'b0;
  logic [7:0]  dl_data = 8'd0;
  logic        dl_wait;
  logic        wr_slot;
  logic        load_color;
  logic [5:0]  load_color_index;
  logic [23:0] load_color_data;
  logic        pal_loaded;
  logic        overrun;

  palette_loader #(.ENTRIES(ENTRIES), .PAL_INDEX(8'd2)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .dl_download      (dl_download),
    .dl_index         (dl_index),
    .dl_wr            (dl_wr),
    .dl_data          (dl_data),
    .dl_wait          (dl_wait),
    .wr_slot          (wr_slot),
    .load_color       (load_color),
    .load_color_index (load_color_index),
    .load_color_data  (load_color_data),
    .pal_loaded       (pal_loaded),
    .overrun          (overrun)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // wr_slot source: 0 = tied high, 1 = random, 2 = manual
  int   slot_mode   = 0;
  logic slot_rand   = 1'b0;
  logic slot_manual = 1'b0;
  always @(negedge clk) slot_rand <= 1'($urandom_range(0, 1));
  assign wr_slot = (slot_mode == 0) ? 1'b1 : (slot_mode == 1) ? slot_rand : slot_manual;

  typedef struct {
    logic [5:0]  idx;
    logic [23:0] data;
    int          cyc;
  } pulse_t;
  pulse_t obs_q[$];
  always @(negedge clk) if (load_color) obs_q.push_back('{load_color_index, load_color_data, cyc});

  typedef struct {
    int len;
    int mode;
    bit rand_data;
    bit gaps;
    int exp_writes;
    bit exp_pl;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Called at a negedge; honours dl_wait, returns the cycle the strobe was driven.
  task automatic send_byte(input logic [7:0] b, output int c);
    int guard = 0;
    while (dl_wait && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (dl_wait) check("dl_wait_timeout", 32'(dl_wait), 32'd0);
    dl_wr   = 1'b1;
    dl_data = b;
    c       = cyc;
    @(negedge clk);
    dl_wr = 1'b0;
  endtask

  task automatic wait_idle();
    int guard = 0;
    while (dl_wait && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (dl_wait) check("drain_timeout", 32'(dl_wait), 32'd0);
    repeat (4) @(negedge clk);
  endtask

  task automatic run_download(input int len, input int mode, input bit rand_data, input bit gaps,
                              input int exp_writes, input bit exp_pl, input string tag);
    logic [7:0] bytes[$];
    int         tcyc[$];
    int         c;
    for (int j = 0; j < len; j++)
      bytes.push_back(rand_data ? 8'($urandom) : 8'(j / 3 + j % 3));
    obs_q.delete();
    slot_mode   = mode;
    dl_index    = 8'd2;
    dl_download = 1'b1;
    if (len == 0) @(negedge clk);
    for (int j = 0; j < len; j++) begin
      if (gaps && j > 0) repeat ($urandom_range(0, 2)) @(negedge clk);
      send_byte(bytes[j], c);
      if (j % 3 == 2) tcyc.push_back(c);
      if (j >= 3 * ENTRIES) check({tag, "_extra_no_wait"}, 32'(dl_wait), 32'd0);
    end
    dl_download = 1'b0;
    wait_idle();
    check({tag, "_writes"}, 32'(obs_q.size()), 32'(exp_writes));
    for (int k = 0; k < obs_q.size() && k < exp_writes; k++) begin
      check($sformatf("%s_idx%0d", tag, k), 32'(obs_q[k].idx), 32'(k));
      check($sformatf("%s_data%0d", tag, k), 32'(obs_q[k].data),
            32'({bytes[3*k], bytes[3*k+1], bytes[3*k+2]}));
      if (mode == 0)
        check($sformatf("%s_lat%0d", tag, k), 32'(obs_q[k].cyc - tcyc[k]), 32'd2);
    end
    check({tag, "_pal_loaded"}, 32'(pal_loaded), 32'(exp_pl));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    int   c, bad, len, nexp;

    vecs[0] = '{192, 0, 0, 0, 64, 1};
    vecs[1] = '{100, 0, 0, 0, 33, 0};
    vecs[2] = '{195, 0, 0, 0, 64, 0};
    vecs[3] = '{3,   1, 1, 1, 1,  0};
    vecs[4] = '{192, 1, 1, 1, 64, 1};
    vecs[5] = '{191, 1, 1, 0, 63, 0};

    repeat (2) @(negedge clk);
    check("reset_outputs",
          32'({dl_wait, load_color, pal_loaded, overrun, load_color_index, load_color_data}), 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++)
      run_download(vecs[i].len, vecs[i].mode, vecs[i].rand_data, vecs[i].gaps,
                   vecs[i].exp_writes, vecs[i].exp_pl, $sformatf("vec%0d", i));

    for (int i = 0; i < 4; i++) begin
      len  = $urandom_range(0, 200);
      nexp = (len / 3 < ENTRIES) ? len / 3 : ENTRIES;
      run_download(len, 1, 1'b1, 1'b1, nexp, len == 3 * ENTRIES, $sformatf("rnd%0d", i));
    end

    // Stall: entry held for 50 cycles without a slot
    obs_q.delete();
    slot_mode = 2; slot_manual = 1'b0;
    dl_index = 8'd2; dl_download = 1'b1;
    send_byte(8'h11, c); send_byte(8'h22, c); send_byte(8'h33, c);
    bad = 0;
    repeat (50) begin
      if (!dl_wait || load_color) bad++;
      @(negedge clk);
    end
    check("stall_hold_bad_cycles", 32'(bad), 32'd0);
    slot_manual = 1'b1;
    @(negedge clk);
    slot_manual = 1'b0;
    check("stall_pulse", 32'({load_color, dl_wait}), 32'b11);
    check("stall_idx", 32'(load_color_index), 32'd0);
    check("stall_data", 32'(load_color_data), 32'h112233);
    @(negedge clk);
    check("stall_after", 32'({load_color, dl_wait}), 32'b00);
    dl_download = 1'b0;
    wait_idle();
    check("stall_pulse_count", 32'(obs_q.size()), 32'd1);

    // Overrun: byte during dl_wait is dropped and does not shift the lanes
    slot_manual = 1'b0;
    dl_download = 1'b1;
    send_byte(8'h01, c); send_byte(8'h02, c); send_byte(8'h03, c);
    check("ovr_before", 32'(overrun), 32'd0);
    dl_wr = 1'b1; dl_data = 8'hEE;
    @(negedge clk);
    dl_wr = 1'b0;
    check("ovr_set", 32'(overrun), 32'd1);
    slot_manual = 1'b1;
    @(negedge clk);
    slot_manual = 1'b0;
    check("ovr_e0", 32'({load_color, load_color_index, load_color_data}), 32'({1'b1, 6'd0, 24'h010203}));
    @(negedge clk);
    send_byte(8'h04, c); send_byte(8'h05, c); send_byte(8'h06, c);
    slot_manual = 1'b1;
    @(negedge clk);
    slot_manual = 1'b0;
    check("ovr_e1", 32'({load_color, load_color_index, load_color_data}), 32'({1'b1, 6'd1, 24'h040506}));
    dl_download = 1'b0;
    wait_idle();
    check("ovr_sticky", 32'(overrun), 32'd1);
    dl_download = 1'b1;
    @(negedge clk);
    check("ovr_cleared", 32'(overrun), 32'd0);
    dl_download = 1'b0;
    wait_idle();

    // Foreign index leaves everything alone
    run_download(192, 0, 1'b1, 1'b0, 64, 1'b1, "pre_idx");
    obs_q.delete();
    dl_index = 8'd1; dl_download = 1'b1;
    bad = 0;
    for (int j = 0; j < 9; j++) begin
      send_byte(8'(j + 8'h40), c);
      if (dl_wait) bad++;
    end
    dl_download = 1'b0;
    wait_idle();
    check("idx1_writes", 32'(obs_q.size()), 32'd0);
    check("idx1_wait_cycles", 32'(bad), 32'd0);
    check("idx1_pal_loaded", 32'(pal_loaded), 32'd1);

    // Reset while an entry is pending
    slot_mode = 2; slot_manual = 1'b0;
    dl_index = 8'd2; dl_download = 1'b1;
    send_byte(8'hA1, c); send_byte(8'hA2, c); send_byte(8'hA3, c);
    check("rst_pending_wait", 32'(dl_wait), 32'd1);
    #2 reset_n = 1'b0;
    #1 check("rst_outputs",
             32'({dl_wait, load_color, pal_loaded, overrun, load_color_index, load_color_data}), 32'd0);
    dl_download = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    run_download(192, 1, 1'b1, 1'b1, 64, 1'b1, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
